// File: rtl/gtx_spi_pkg.sv
// Shared types and constants for the SPI transfer engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, SPI mode constants as {cpol,cpha}, and
// counter-width helpers used to size the edge counter and slave index.
package gtx_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Edge counter must hold 0..2*xfer_w without wrapping.
    function automatic int edge_cnt_w(input int xfer_w);
        return $clog2(2 * xfer_w + 1);
    endfunction

    // Slave index is wide enough to also encode nss itself, the "no slave"
    // code that routes the default MISO line.
    function automatic int ssidx_w(input int nss);
        return $clog2(nss + 1);
    endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// SCK half-period divider: one-cycle tick every div+1 cycles while running.
// Latency: first tick div+1 cycles after load; reload on each tick.
// Backpressure: none; free-running while run is high.
//
// Ports: CLK/RST clock and async active-high reset; load reloads the count
// from div (transfer start); run enables counting; tick marks a half-period.
module spi_clkdiv #(
    parameter int DIV_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= div;
        end else if (run) begin
            cnt_q <= (cnt_q == '0) ? div : cnt_q - 1'b1;
        end
    end

    assign tick = run && (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_master.sv
// Full-duplex SPI shift engine with programmable divider, mode and bit order.
// Latency: busy for (2*XFER_W+1)*(cfg_div+1) cycles; done on first idle cycle.
// Backpressure: start and cfg_we are ignored while busy; no queueing.
//
// Ports: CLK/RST; cfg_* configuration (latched in IDLE on cfg_we);
// start/tx_data launch a transfer; rx_data/busy/done report it;
// SCK/MOSI/nSS drive the bus; MISO[NSS] is the line read with no slave selected.
module spi_xfer_master
    import gtx_spi_pkg::*;
#(
    parameter int NSS    = 2,
    parameter int XFER_W = 8,
    parameter int DIV_W  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cfg_we,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic                    cfg_cpol,
    input  logic                    cfg_cpha,
    input  logic                    cfg_lsb,
    input  logic                    cfg_ssen,
    input  logic [ssidx_w(NSS)-1:0] cfg_ssidx,
    input  logic                    start,
    input  logic [XFER_W-1:0]       tx_data,
    output logic [XFER_W-1:0]       rx_data,
    output logic                    busy,
    output logic                    done,
    output logic                    SCK,
    output logic                    MOSI,
    input  logic [NSS:0]            MISO,
    output logic [NSS-1:0]          nSS
);

    localparam int SW  = ssidx_w(NSS);
    localparam int ECW = edge_cnt_w(XFER_W);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic              cpol_q, cpha_q, lsb_q, ssen_q;
    logic [SW-1:0]     ssidx_q;
    logic [XFER_W-1:0] tx_sh, rx_sh, rx_q;
    logic [ECW-1:0]    ecnt_q;
    logic              sck_q, mosi_q, done_q;

    logic              tick, accept, cfg_ok;
    logic              tog, last_tog, sample_en, drive_en, finish;
    logic [SW-1:0]     miso_sel;
    logic              miso_bit;

    function automatic logic lead_bit(input logic [XFER_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[XFER_W-1];
    endfunction

    function automatic logic [XFER_W-1:0] shift_out(input logic [XFER_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Received bits enter at the far end so the first bit lands in rx[0]
    // for LSB-first and in rx[XFER_W-1] for MSB-first.
    function automatic logic [XFER_W-1:0] shift_in(input logic [XFER_W-1:0] w, input logic b,
                                                   input logic lsb);
        return lsb ? {b, w[XFER_W-1:1]} : {w[XFER_W-2:0], b};
    endfunction

    // Config wins over start in the same cycle; start is dropped.
    assign cfg_ok = (state_q == IDLE) && cfg_we;
    assign accept = (state_q == IDLE) && start && !cfg_we;

    spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
        .CLK  (CLK),
        .RST  (RST),
        .load (accept),
        .run  (state_q != IDLE),
        .div  (div_q),
        .tick (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = SHIFT;
            SHIFT:   if (last_tog) state_d = TAIL;
            TAIL:    if (tick)     state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Toggle number is ecnt_q+1: odd toggles have ecnt_q[0]==0.
    // CPHA=0 samples odd / drives even; CPHA=1 the reverse. The final toggle
    // only returns SCK to idle and never drives a new bit.
    always_comb begin
        busy      = (state_q != IDLE);
        tog       = (state_q == SHIFT) && tick;
        last_tog  = tog && (ecnt_q == ECW'(2 * XFER_W - 1));
        sample_en = tog && (ecnt_q[0] == cpha_q);
        drive_en  = tog && (ecnt_q[0] != cpha_q) && !last_tog;
        finish    = (state_q == TAIL) && tick;
    end

    assign miso_sel = (ssen_q && (ssidx_q < SW'(NSS))) ? ssidx_q : SW'(NSS);
    assign miso_bit = MISO[miso_sel];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            ssen_q  <= 1'b0;
            ssidx_q <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_q    <= '0;
            ecnt_q  <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (cfg_ok) begin
                div_q   <= cfg_div;
                cpol_q  <= cfg_cpol;
                cpha_q  <= cfg_cpha;
                lsb_q   <= cfg_lsb;
                ssen_q  <= cfg_ssen;
                ssidx_q <= cfg_ssidx;
            end
            if (state_q == IDLE) begin
                sck_q  <= cfg_ok ? cfg_cpol : cpol_q;
                mosi_q <= 1'b1;
                if (accept) begin
                    ecnt_q <= '0;
                    rx_sh  <= '0;
                    // CPHA=0 presents the first bit before the first edge.
                    if (!cpha_q) begin
                        mosi_q <= lead_bit(tx_data, lsb_q);
                        tx_sh  <= shift_out(tx_data, lsb_q);
                    end else begin
                        tx_sh  <= tx_data;
                    end
                end
            end else begin
                if (tog) begin
                    sck_q  <= ~sck_q;
                    ecnt_q <= ecnt_q + 1'b1;
                end
                if (drive_en) begin
                    mosi_q <= lead_bit(tx_sh, lsb_q);
                    tx_sh  <= shift_out(tx_sh, lsb_q);
                end
                if (sample_en) begin
                    rx_sh <= shift_in(rx_sh, miso_bit, lsb_q);
                end
                if (finish) begin
                    rx_q   <= rx_sh;
                    mosi_q <= 1'b1;
                end
            end
        end
    end

    // Selects come straight from config registers, which only change in IDLE.
    always_comb begin
        for (int i = 0; i < NSS; i++) begin
            nSS[i] = !(ssen_q && (ssidx_q == SW'(i)));
        end
    end

    assign SCK     = sck_q;
    assign MOSI    = mosi_q;
    assign done    = done_q;
    assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_xfer_master.sv
module tb_spi_xfer_master;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_div = '0;
    logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0, cfg_ssen = 1'b0;
    logic [1:0] cfg_ssidx = '0;
    logic       start = 1'b0;
    logic [7:0] tx_data = '0;
    logic [7:0] rx_data;
    logic       busy, done, SCK, MOSI;
    logic [2:0] MISO;
    logic [1:0] nSS;

    always #5 CLK = ~CLK;

    spi_xfer_master #(.NSS(2), .XFER_W(8), .DIV_W(4)) dut (
        .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .cfg_lsb(cfg_lsb), .cfg_ssen(cfg_ssen), .cfg_ssidx(cfg_ssidx),
        .start(start), .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
        .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .nSS(nSS)
    );

    // MISO sources: per-line loopback of MOSI, constants, or a serializer on line 2
    logic [2:0] loop_en = 3'b100;
    logic [2:0] miso_c  = 3'b000;
    logic       ser_en = 1'b0, ser_lsb = 1'b0, ser_bit;
    logic [7:0] ser_word = '0;
    int         ser_i = 0, ser_base = 0, ser_k;

    always @(posedge SCK) ser_i <= ser_i + 1;
    assign ser_k = ser_i - ser_base;

    always_comb begin
        ser_bit = 1'b0;
        if (ser_k >= 0 && ser_k < 8) ser_bit = ser_lsb ? ser_word[ser_k] : ser_word[7 - ser_k];
    end

    always_comb begin
        MISO = '0;
        for (int i = 0; i < 3; i++) MISO[i] = loop_en[i] ? MOSI : miso_c[i];
        if (ser_en) MISO[2] = ser_bit;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [3:0] d, input logic pol, input logic pha, input logic lsb,
                           input logic ssen, input logic [1:0] idx);
        @(negedge CLK);
        cfg_we = 1'b1; cfg_div = d; cfg_cpol = pol; cfg_cpha = pha; cfg_lsb = lsb;
        cfg_ssen = ssen; cfg_ssidx = idx;
        @(negedge CLK);
        cfg_we = 1'b0;
    endtask

    // Measurements from the last transfer
    int         m_busy, m_early_done, m_rises, m_period, m_tog;
    logic       m_nss_chg, m_done_end, m_done_after, m_sck_end, m_mosi_end;
    logic [1:0] m_nss;
    logic [7:0] m_rx, m_mosi_raw;

    task automatic do_xfer(input logic [7:0] tx, input logic pha, input bit inj);
        logic prev_sck;
        int   r0, si;
        @(negedge CLK);
        prev_sck = SCK;
        start = 1'b1; tx_data = tx;
        @(negedge CLK);
        start = 1'b0;
        m_busy = 0; m_early_done = 0; m_rises = 0; m_period = -1; m_tog = 0;
        m_nss_chg = 1'b0; m_nss = nSS; m_mosi_raw = '0; r0 = -1; si = 0;
        while (busy === 1'b1 && m_busy < 2000) begin
            m_busy++;
            if (done === 1'b1) m_early_done++;
            if (nSS !== m_nss) m_nss_chg = 1'b1;
            if (SCK !== prev_sck) begin
                m_tog++;
                if ((m_tog % 2 == 1) != pha) begin
                    if (si < 8) m_mosi_raw[si] = MOSI;
                    si++;
                end
                if (SCK === 1'b1) begin
                    m_rises++;
                    if (r0 < 0) r0 = m_busy;
                    else if (m_period < 0) m_period = m_busy - r0;
                end
            end
            prev_sck = SCK;
            if (inj && m_busy == 5) begin
                start = 1'b1; cfg_we = 1'b1; cfg_div = 4'd7;
            end
            @(negedge CLK);
            if (inj) begin start = 1'b0; cfg_we = 1'b0; end
        end
        m_done_end = done; m_rx = rx_data; m_sck_end = SCK; m_mosi_end = MOSI;
        @(negedge CLK);
        m_done_after = done;
    endtask

    typedef struct {
        logic [3:0] div;
        logic       cpol, cpha, lsb, ssen;
        logic [1:0] idx;
        logic [2:0] loop_en, miso_c;
        logic [7:0] tx, exp_rx, exp_mosi;
        int         exp_busy, exp_period;
        logic [1:0] exp_nss;
        bit         inj;
    } vec_t;

    vec_t vecs[9];

    initial begin
        //          div  pol  pha  lsb  ssen idx    loop     mc       tx     rx     mosi   busy per nss   inj
        vecs[0] = '{4'd0, 1'b0,1'b0,1'b0,1'b0,2'd0,3'b100,3'b000,8'hA5,8'hA5,8'hA5, 17,  2,2'b11,1'b0};
        vecs[1] = '{4'd3, 1'b1,1'b1,1'b0,1'b1,2'd1,3'b000,3'b010,8'h5A,8'hFF,8'h5A, 68,  8,2'b01,1'b0};
        vecs[2] = '{4'd2, 1'b0,1'b1,1'b1,1'b0,2'd0,3'b100,3'b000,8'h3C,8'h3C,8'h3C, 51,  6,2'b11,1'b0};
        vecs[3] = '{4'd1, 1'b1,1'b0,1'b0,1'b1,2'd0,3'b001,3'b100,8'hC3,8'hC3,8'hC3, 34,  4,2'b10,1'b0};
        vecs[4] = '{4'd0, 1'b0,1'b0,1'b0,1'b1,2'd2,3'b100,3'b011,8'h96,8'h96,8'h69, 17,  2,2'b11,1'b0};
        vecs[5] = '{4'd0, 1'b0,1'b0,1'b0,1'b1,2'd0,3'b100,3'b000,8'hF0,8'h00,8'h0F, 17,  2,2'b10,1'b0};
        vecs[6] = '{4'd15,1'b0,1'b0,1'b0,1'b0,2'd0,3'b100,3'b000,8'h81,8'h81,8'h81, 272,32,2'b11,1'b0};
        vecs[7] = '{4'd0, 1'b0,1'b0,1'b1,1'b0,2'd0,3'b100,3'b000,8'h01,8'h01,8'h01, 17,  2,2'b11,1'b0};
        vecs[8] = '{4'd1, 1'b0,1'b0,1'b0,1'b0,2'd0,3'b100,3'b000,8'h5A,8'h5A,8'h5A, 34,  4,2'b11,1'b1};

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_sck", SCK, 1'b0);
        chk("rst_mosi", MOSI, 1'b1);
        chk("rst_nss", nSS, 2'b11);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rx", rx_data, 8'h00);
        RST = 1'b0;

        for (int v = 0; v < 9; v++) begin
            loop_en = vecs[v].loop_en; miso_c = vecs[v].miso_c;
            set_cfg(vecs[v].div, vecs[v].cpol, vecs[v].cpha, vecs[v].lsb, vecs[v].ssen, vecs[v].idx);
            @(negedge CLK);
            chk($sformatf("v%0d_idle_sck", v), SCK, vecs[v].cpol);
            do_xfer(vecs[v].tx, vecs[v].cpha, vecs[v].inj);
            chk($sformatf("v%0d_rx", v), m_rx, vecs[v].exp_rx);
            chk($sformatf("v%0d_busy_cycles", v), m_busy, vecs[v].exp_busy);
            chk($sformatf("v%0d_done_end", v), m_done_end, 1'b1);
            chk($sformatf("v%0d_done_after", v), m_done_after, 1'b0);
            chk($sformatf("v%0d_early_done", v), m_early_done, 0);
            chk($sformatf("v%0d_sck_rises", v), m_rises, 8);
            chk($sformatf("v%0d_sck_period", v), m_period, vecs[v].exp_period);
            chk($sformatf("v%0d_nss", v), m_nss, vecs[v].exp_nss);
            chk($sformatf("v%0d_nss_stable", v), m_nss_chg, 1'b0);
            chk($sformatf("v%0d_mosi_bits", v), m_mosi_raw, vecs[v].exp_mosi);
            chk($sformatf("v%0d_sck_end", v), m_sck_end, vecs[v].cpol);
            chk($sformatf("v%0d_mosi_end", v), m_mosi_end, 1'b1);
        end

        // The mid-transfer cfg_we of the last vector must not have changed the divider
        do_xfer(8'h33, 1'b0, 1'b0);
        chk("inj_followup_busy", m_busy, 34);
        chk("inj_followup_rx", m_rx, 8'h33);

        // Config and start in the same idle cycle: config taken, start dropped
        @(negedge CLK);
        cfg_we = 1'b1; start = 1'b1; cfg_div = 4'd0; cfg_cpol = 1'b1; cfg_cpha = 1'b1;
        cfg_lsb = 1'b0; cfg_ssen = 1'b0; tx_data = 8'h11;
        @(negedge CLK);
        cfg_we = 1'b0; start = 1'b0;
        chk("cfgstart_busy", busy, 1'b0);
        chk("cfgstart_sck_cpol", SCK, 1'b1);
        @(negedge CLK);
        chk("cfgstart_busy_later", busy, 1'b0);

        // RX bit order against an independent serial source on MISO[2]
        for (int o = 0; o < 2; o++) begin
            set_cfg(4'd0, 1'b0, 1'b0, o[0], 1'b0, 2'd0);
            ser_word = 8'h6B; ser_lsb = o[0]; ser_base = ser_i; ser_en = 1'b1;
            do_xfer(8'h00, 1'b0, 1'b0);
            ser_en = 1'b0;
            chk($sformatf("ser_rx_lsb%0d", o), m_rx, 8'h6B);
        end

        // Reset pulse at toggle 6
        loop_en = 3'b100;
        set_cfg(4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        begin
            int   tg, cyc;
            logic ps;
            bit   saw;
            @(negedge CLK);
            ps = SCK; start = 1'b1; tx_data = 8'hC5;
            @(negedge CLK);
            start = 1'b0; tg = 0; cyc = 0;
            while (tg < 6 && cyc < 200) begin
                if (SCK !== ps) tg++;
                ps = SCK;
                if (tg < 6) begin @(negedge CLK); cyc++; end
            end
            chk("rst_mid_reached_tog6", tg, 6);
            RST = 1'b1;
            #1;
            chk("rst_mid_sck", SCK, 1'b0);
            chk("rst_mid_nss", nSS, 2'b11);
            chk("rst_mid_busy", busy, 1'b0);
            chk("rst_mid_mosi", MOSI, 1'b1);
            chk("rst_mid_rx", rx_data, 8'h00);
            @(negedge CLK);
            RST = 1'b0;
            saw = 1'b0;
            repeat (40) begin
                @(negedge CLK);
                if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
            end
            chk("rst_mid_no_done", saw, 1'b0);
        end
        set_cfg(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        do_xfer(8'h5A, 1'b0, 1'b0);
        chk("post_rst_rx", m_rx, 8'h5A);
        chk("post_rst_busy", m_busy, 17);
        chk("post_rst_done", m_done_end, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
